// File: rtl/load_store_unit.sv
// RV32I load/store unit: sizes, lane-aligns and sign/zero-extends accesses to a 1-cycle-latency memory.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of aligning.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Req,
  output logic        o_Ready,
  input  logic        i_We,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_Wd,
  output logic [31:0] o_Rd,
  output logic        o_Done,
  output logic        o_Misaligned,
  output logic [31:0] o_Mem_Addr,
  output logic [31:0] o_Mem_Wd,
  output logic [3:0]  o_Mem_Wen,
  output logic        o_Mem_Ren,
  input  logic [31:0] i_Mem_Rd
);

  typedef enum logic [2:0] {StIdle, StWrite, StWriteHi, StRead, StCapture} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wd_q, rd_q, rd_fmt;
  logic        done_q, done_d, mis_q, mis_d;
  logic        accept, req_ok, req_mis, is_half, is_word, split;
  logic [31:0] addr_eff, wd_rep;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept  = i_Req && (state_q == StIdle);
  assign is_half = (i_Funct3[1:0] == 2'b01);
  assign is_word = (i_Funct3[1:0] == 2'b10);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis  = (is_half && i_Addr[0]) || (is_word && (i_Addr[1:0] != 2'b00));
  assign addr_eff = i_Addr;
`else
  assign req_mis  = 1'b0;
  assign addr_eff = is_word ? {i_Addr[31:2], 2'b00} :
                    is_half ? {i_Addr[31:1], 1'b0}  : i_Addr;
`endif

  always_comb begin
    req_ok = 1'b0;
    case (i_Funct3)
      3'b000, 3'b001, 3'b010: req_ok = 1'b1;
      3'b100, 3'b101:         req_ok = !i_We;
      default:                req_ok = 1'b0;
    endcase
  end

  always_comb begin
    wd_rep = i_Wd;
    case (i_Funct3[1:0])
      2'b00:   wd_rep = {4{i_Wd[7:0]}};
      2'b01:   wd_rep = {2{i_Wd[15:0]}};
      default: wd_rep = i_Wd;
    endcase
  end

  // A halfword at offset 2 is written as two single-byte strobes, never as 1100.
  assign split = (funct3_q[1:0] == 2'b01) && addr_q[1];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Req) begin
          if (!req_ok || req_mis) begin
            done_d = 1'b1;
            mis_d  = req_ok && req_mis;
          end else begin
            state_d = i_We ? StWrite : StRead;
          end
        end
      end
      StWrite: begin
        if (split) begin
          state_d = StWriteHi;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StWriteHi: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      StRead:    state_d = StCapture;
      StCapture: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default:   state_d = StIdle;
    endcase
  end

  assign lane_b = i_Mem_Rd[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = addr_q[1] ? i_Mem_Rd[31:16] : i_Mem_Rd[15:0];

  always_comb begin
    rd_fmt = i_Mem_Rd;
    case (funct3_q)
      3'b000:  rd_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  rd_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  rd_fmt = {24'h000000, lane_b};
      3'b101:  rd_fmt = {16'h0000, lane_h};
      default: rd_fmt = i_Mem_Rd;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      if (accept) begin
        funct3_q <= i_Funct3;
        addr_q   <= addr_eff;
        wd_q     <= wd_rep;
      end
      if (state_q == StCapture) rd_q <= rd_fmt;
    end
  end

  always_comb begin
    o_Mem_Wen = 4'b0000;
    if (state_q == StWrite) begin
      case (funct3_q[1:0])
        2'b00:   o_Mem_Wen = 4'b0001 << addr_q[1:0];
        2'b01:   o_Mem_Wen = addr_q[1] ? 4'b0100 : 4'b0011;
        default: o_Mem_Wen = 4'b1111;
      endcase
    end else if (state_q == StWriteHi) begin
      o_Mem_Wen = 4'b1000;
    end
  end

  assign o_Ready      = (state_q == StIdle);
  assign o_Mem_Ren    = (state_q == StRead);
  assign o_Mem_Addr   = (state_q != StIdle) ? addr_q : '0;
  assign o_Mem_Wd     = ((state_q == StWrite) || (state_q == StWriteHi)) ? wd_q : '0;
  assign o_Rd         = rd_q;
  assign o_Done       = done_q;
  assign o_Misaligned = mis_q;

endmodule
